// File: rtl/attex_bus_fabric.sv
// 68070-side bus fabric: address decode to chip selects, read-data/ack return path,
// interrupt-acknowledge service, bus error on unmapped or stalled accesses.
module attex_bus_fabric #(
  parameter int NUM_SLAVES = 4,
  parameter logic [24*NUM_SLAVES-1:0] SLAVE_BASE =
    {24'h000000, 24'h320000, 24'h310000, 24'h300000},
  parameter logic [24*NUM_SLAVES-1:0] SLAVE_MASK =
    {24'hC00000, 24'hFF0000, 24'hFF0000, 24'hFF0000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk30,
  input  logic                    reset,
  input  logic                    cpu_as,
  input  logic                    cpu_uds,
  input  logic                    cpu_lds,
  input  logic                    cpu_write_strobe,
  input  logic [23:1]             cpu_addr,
  input  logic                    cpu_iack,
  input  logic [15:0]             iack_dout,
  output logic [NUM_SLAVES-1:0]   slave_cs,
  input  logic [16*NUM_SLAVES-1:0] slave_dout,
  input  logic [NUM_SLAVES-1:0]   slave_ack,
  output logic [15:0]             cpu_din,
  output logic                    cpu_bus_ack,
  output logic                    cpu_bus_err,
  output logic [23:0]             last_err_addr,
  output logic                    last_err_timeout,
  output logic [7:0]              err_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR, HOLD} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [23:0]             lastErrAddr_q, lastErrAddr_d;
  logic                    lastErrTimeout_q, lastErrTimeout_d;
  logic [7:0]              errCount_q, errCount_d;

  logic [23:0]             addrByte;
  logic [NUM_SLAVES-1:0]   hit;
  logic [NUM_SLAVES-1:0]   selOneHot;
  logic                    found;
  logic                    hitValid;
  logic [15:0]             readData;
  logic                    ackSel;
  logic                    access;
  logic                    unusedWrite;

  // Reads and writes decode identically, so the direction strobe is not needed here.
  assign unusedWrite = cpu_write_strobe;

  assign addrByte = {cpu_addr, 1'b0};
  assign access   = cpu_as && (cpu_uds || cpu_lds) && !cpu_iack;

  // Region decode; the lowest matching index wins so overlapping regions nest cleanly.
  always_comb begin
    hit       = '0;
    selOneHot = '0;
    found     = 1'b0;
    readData  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = ((addrByte & SLAVE_MASK[24*i +: 24]) == SLAVE_BASE[24*i +: 24]);
      if (hit[i] && !found) begin
        selOneHot[i] = 1'b1;
        found        = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (selOneHot[i]) begin
        readData = readData | slave_dout[16*i +: 16];
      end
    end
  end

  assign hitValid = |hit;
  assign ackSel   = |(slave_ack & selOneHot);

  // CPU-facing outputs are pass-through; reset forces them quiet regardless of AS.
  always_comb begin
    slave_cs    = '0;
    cpu_din     = '0;
    cpu_bus_ack = 1'b0;
    cpu_bus_err = 1'b0;
    if (!reset) begin
      cpu_bus_err = (state_q == ERR);
      if (cpu_iack) begin
        cpu_din     = iack_dout;
        cpu_bus_ack = 1'b1;
      end else begin
        cpu_din = readData;
        if (cpu_as && state_q != ERR) begin
          slave_cs    = selOneHot;
          cpu_bus_ack = ackSel && hitValid;
        end
      end
    end
  end

  // Access FSM and watchdog; an iack cycle freezes both.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    lastErrAddr_d    = lastErrAddr_q;
    lastErrTimeout_d = lastErrTimeout_q;
    errCount_d       = errCount_q;
    if (!cpu_iack) begin
      case (state_q)
        IDLE: begin
          if (access) begin
            if (!hitValid) begin
              state_d          = ERR;
              lastErrAddr_d    = addrByte;
              lastErrTimeout_d = 1'b0;
              errCount_d       = (errCount_q == 8'hFF) ? errCount_q : errCount_q + 8'd1;
            end else if (ackSel) begin
              state_d = HOLD;
            end else begin
              state_d = ACTIVE;
              count_d = '0;
            end
          end
        end
        ACTIVE: begin
          if (!cpu_as) begin
            state_d = IDLE;
          end else if (ackSel) begin
            state_d = HOLD;
          end else if (count_q == TIMEOUT_LAST) begin
            state_d          = ERR;
            lastErrAddr_d    = addrByte;
            lastErrTimeout_d = 1'b1;
            errCount_d       = (errCount_q == 8'hFF) ? errCount_q : errCount_q + 8'd1;
          end else begin
            count_d = count_q + 16'd1;
          end
        end
        ERR, HOLD: begin
          if (!cpu_as) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk30) begin
    if (reset) begin
      state_q          <= IDLE;
      count_q          <= '0;
      lastErrAddr_q    <= '0;
      lastErrTimeout_q <= 1'b0;
      errCount_q       <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      lastErrAddr_q    <= lastErrAddr_d;
      lastErrTimeout_q <= lastErrTimeout_d;
      errCount_q       <= errCount_d;
    end
  end

  assign last_err_addr    = lastErrAddr_q;
  assign last_err_timeout = lastErrTimeout_q;
  assign err_count        = errCount_q;

endmodule
